// File: rtl/display_pkg.sv
// Shared constants for the display path: set-mode codes, digit positions
// and 7-segment glyphs (active-high; polarity is applied at the pins).
package display_pkg;

   typedef enum logic [1:0] {
      MODE_RUN  = 2'd0,
      MODE_HOUR = 2'd1,
      MODE_MIN  = 2'd2,
      MODE_SEC  = 2'd3
   } mode_t;

   localparam logic [2:0] IDX_SEC_U  = 3'd0;
   localparam logic [2:0] IDX_SEC_T  = 3'd1;
   localparam logic [2:0] IDX_MIN_U  = 3'd2;
   localparam logic [2:0] IDX_MIN_T  = 3'd3;
   localparam logic [2:0] IDX_HOUR_U = 3'd4;
   localparam logic [2:0] IDX_HOUR_T = 3'd5;

   // {g,f,e,d,c,b,a}, 1 = segment lit
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   // Which settable field a digit position belongs to
   function automatic mode_t field_of_idx(input logic [2:0] idx);
      case (idx)
         IDX_SEC_U,  IDX_SEC_T:  field_of_idx = MODE_SEC;
         IDX_MIN_U,  IDX_MIN_T:  field_of_idx = MODE_MIN;
         IDX_HOUR_U, IDX_HOUR_T: field_of_idx = MODE_HOUR;
         default:                field_of_idx = MODE_RUN;
      endcase
   endfunction

endpackage

// File: rtl/display_scan_bin2bcd.sv
// 6-bit binary to two BCD digits via a compare ladder (valid for 0..63).
module bin2bcd_6b (
   input  logic [5:0] bin,
   output logic [3:0] tens,
   output logic [3:0] units
);

   // Pick the tens digit by threshold, units is the remainder
   always_comb begin
      if (bin >= 6'd60) begin
         tens  = 4'd6;
         units = 4'(bin - 6'd60);
      end else if (bin >= 6'd50) begin
         tens  = 4'd5;
         units = 4'(bin - 6'd50);
      end else if (bin >= 6'd40) begin
         tens  = 4'd4;
         units = 4'(bin - 6'd40);
      end else if (bin >= 6'd30) begin
         tens  = 4'd3;
         units = 4'(bin - 6'd30);
      end else if (bin >= 6'd20) begin
         tens  = 4'd2;
         units = 4'(bin - 6'd20);
      end else if (bin >= 6'd10) begin
         tens  = 4'd1;
         units = 4'(bin - 6'd10);
      end else begin
         tens  = 4'd0;
         units = bin[3:0];
      end
   end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 6-digit 7-segment driver for HH.MM.SS with blinking of
// the field currently being set.
module display_scan #(
   parameter int NUM_DIGITS     = 6,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena_scan,
   input  logic                  ena_5hz,
   input  logic [1:0]            select_mode,
   input  logic [5:0]            hour,
   input  logic [5:0]            min,
   input  logic [5:0]            sec,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp
);

   import display_pkg::*;

   localparam logic POL = (SEG_ACTIVE_LOW != 0);

   logic [2:0] idx_q, idx_d;
   logic       blink_q, blink_d;
   mode_t      last_mode_q, mode_cur;

   logic [3:0] h_t, h_u, m_t, m_u, s_t, s_u;
   logic [3:0] digit;
   logic [NUM_DIGITS-1:0] an_h;
   logic [6:0] seg_h;
   logic       dp_h;
   logic       blank;

   bin2bcd_6b u_bcd_hour (.bin(hour), .tens(h_t), .units(h_u));
   bin2bcd_6b u_bcd_min  (.bin(min),  .tens(m_t), .units(m_u));
   bin2bcd_6b u_bcd_sec  (.bin(sec),  .tens(s_t), .units(s_u));

   // Next scan index and blink phase; a mode change overrides the 5 Hz toggle
   always_comb begin
      mode_cur = mode_t'(select_mode);
      idx_d    = idx_q;
      if (ena_scan)
         idx_d = (idx_q >= IDX_HOUR_T) ? 3'd0 : idx_q + 3'd1;
      blink_d = blink_q;
      if (mode_cur != last_mode_q)
         blink_d = 1'b0;
      else if (ena_5hz)
         blink_d = ~blink_q;
   end

   // Decode the next-state digit so the registered pins track ena_scan with
   // one cycle of latency rather than two
   always_comb begin
      digit = '0;
      an_h  = '0;
      dp_h  = 1'b0;
      case (idx_d)
         IDX_SEC_U:  begin digit = s_u; an_h[0] = 1'b1; end
         IDX_SEC_T:  begin digit = s_t; an_h[1] = 1'b1; end
         IDX_MIN_U:  begin digit = m_u; an_h[2] = 1'b1;
                           dp_h = (mode_cur != MODE_RUN) || !sec[0]; end
         IDX_MIN_T:  begin digit = m_t; an_h[3] = 1'b1; end
         IDX_HOUR_U: begin digit = h_u; an_h[4] = 1'b1;
                           dp_h = (mode_cur != MODE_RUN) || !sec[0]; end
         IDX_HOUR_T: begin digit = h_t; an_h[5] = 1'b1; end
         default:    begin digit = '0;  an_h = '0; end
      endcase
      seg_h = '0;
      if (digit <= 4'd9)
         seg_h = SEG_DIGIT[digit];
      blank = blink_d && (mode_cur != MODE_RUN) &&
              (mode_cur == field_of_idx(idx_d));
      if (blank) begin
         an_h  = '0;
         seg_h = '0;
      end
   end

   // State and output registers; outputs go inactive asynchronously on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         blink_q     <= 1'b0;
         last_mode_q <= MODE_RUN;
         an          <= {NUM_DIGITS{POL}};
         seg         <= {7{POL}};
         dp          <= POL;
      end else begin
         idx_q       <= idx_d;
         blink_q     <= blink_d;
         last_mode_q <= mode_cur;
         an          <= an_h ^ {NUM_DIGITS{POL}};
         seg         <= seg_h ^ {7{POL}};
         dp          <= dp_h ^ POL;
      end
   end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan (active-low outputs).
module tb_display_scan;

   logic       clk;
   logic       rst_n;
   logic       ena_scan;
   logic       ena_5hz;
   logic [1:0] select_mode;
   logic [5:0] hour, min, sec;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;

   int vectors;
   int miscompares;

   // Active-low glyphs of 12:34:56 by digit index 0..5 (6,5,4,3,2,1)
   logic [6:0] seg_1234 [0:5] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

   display_scan #(.NUM_DIGITS(6), .SEG_ACTIVE_LOW(1)) dut (
      .clk(clk), .rst_n(rst_n), .ena_scan(ena_scan), .ena_5hz(ena_5hz),
      .select_mode(select_mode), .hour(hour), .min(min), .sec(sec),
      .an(an), .seg(seg), .dp(dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_scan();
      ena_scan = 1'b1;
      tick();
      ena_scan = 1'b0;
   endtask

   task automatic pulse_5hz();
      ena_5hz = 1'b1;
      tick();
      ena_5hz = 1'b0;
   endtask

   task automatic do_reset();
      ena_scan = 1'b0;
      ena_5hz  = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      hour = 6'd12; min = 6'd34; sec = 6'd56; select_mode = 2'd0;
      rst_n = 1'b0; ena_scan = 1'b0; ena_5hz = 1'b0;
      tick();
      vectors++;
      if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state: an=%h seg=%h dp=%b expected an=3f seg=7f dp=1", an, seg, dp);
      end
      rst_n = 1'b1;
      pulse_scan(); pulse_scan(); pulse_scan();
      vectors++;
      if (an !== 6'h37 || seg !== 7'h30) begin
         miscompares++;
         $display("FAIL reset_pre_idx3: an=%h seg=%h expected an=37 seg=30", an, seg);
      end
      #3 rst_n = 1'b0;
      #1;
      vectors++;
      if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_async: an=%h seg=%h dp=%b expected an=3f seg=7f dp=1", an, seg, dp);
      end
      tick();
      rst_n = 1'b1;
      pulse_scan();
      vectors++;
      if (an !== 6'h3D || seg !== 7'h12) begin
         miscompares++;
         $display("FAIL reset_first_scan: an=%h seg=%h expected an=3d seg=12", an, seg);
      end
   endtask

   task automatic test_scan();
      logic [5:0] exp_an;
      int e;
      hour = 6'd12; min = 6'd34; sec = 6'd56; select_mode = 2'd0;
      do_reset();
      tick();
      vectors++;
      if (an !== 6'h3E || seg !== 7'h02 || dp !== 1'b1) begin
         miscompares++;
         $display("FAIL scan_idx0: an=%h seg=%h dp=%b expected an=3e seg=02 dp=1", an, seg, dp);
      end
      for (int unsigned i = 1; i <= 7; i++) begin
         pulse_scan();
         e = int'(i % 6);
         exp_an = ~(6'd1 << e);
         vectors++;
         if (an !== exp_an || seg !== seg_1234[e]) begin
            miscompares++;
            $display("FAIL scan_pulse%0d: an=%h seg=%h expected an=%h seg=%h", i, an, seg, exp_an, seg_1234[e]);
         end
         vectors++;
         if (dp !== ((e == 2 || e == 4) ? 1'b0 : 1'b1)) begin
            miscompares++;
            $display("FAIL scan_dp%0d: dp=%b expected %b", i, dp, (e == 2 || e == 4) ? 1'b0 : 1'b1);
         end
      end
   endtask

   task automatic test_bcd_edges();
      logic [5:0] vals  [0:4] = '{6'd0, 6'd9, 6'd10, 6'd59, 6'd63};
      logic [6:0] units [0:4] = '{7'h40, 7'h10, 7'h40, 7'h10, 7'h30};
      logic [6:0] tens  [0:4] = '{7'h40, 7'h40, 7'h79, 7'h12, 7'h02};
      select_mode = 2'd0;
      for (int unsigned i = 0; i < 5; i++) begin
         sec = vals[i];
         do_reset();
         tick();
         vectors++;
         if (an !== 6'h3E || seg !== units[i]) begin
            miscompares++;
            $display("FAIL bcd_units_%0d: an=%h seg=%h expected an=3e seg=%h", vals[i], an, seg, units[i]);
         end
         pulse_scan();
         vectors++;
         if (an !== 6'h3D || seg !== tens[i]) begin
            miscompares++;
            $display("FAIL bcd_tens_%0d: an=%h seg=%h expected an=3d seg=%h", vals[i], an, seg, tens[i]);
         end
      end
   endtask

   task automatic test_blink();
      logic [5:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      logic       phase;
      int e;
      hour = 6'd12; min = 6'd34; sec = 6'd56; select_mode = 2'd2;
      do_reset();
      tick();
      phase = 1'b0;
      for (int unsigned p = 0; p < 4; p++) begin
         for (int unsigned i = 1; i <= 6; i++) begin
            pulse_scan();
            e = int'(i % 6);
            if (phase && (e == 2 || e == 3)) begin
               exp_an = 6'h3F; exp_seg = 7'h7F;
            end else begin
               exp_an = ~(6'd1 << e); exp_seg = seg_1234[e];
            end
            exp_dp = (e == 2 || e == 4) ? 1'b0 : 1'b1;
            vectors++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
               miscompares++;
               $display("FAIL blink_p%0d_idx%0d: an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                        p, e, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
         end
         tick();
         pulse_5hz();
         phase = ~phase;
      end
   endtask

   task automatic test_mode_change();
      hour = 6'd12; min = 6'd34; sec = 6'd56; select_mode = 2'd1;
      do_reset();
      tick();
      pulse_5hz();
      pulse_scan(); pulse_scan(); pulse_scan(); pulse_scan();
      vectors++;
      if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b0) begin
         miscompares++;
         $display("FAIL mode_hour_blank4: an=%h seg=%h dp=%b expected an=3f seg=7f dp=0", an, seg, dp);
      end
      pulse_scan();
      vectors++;
      if (an !== 6'h3F || seg !== 7'h7F) begin
         miscompares++;
         $display("FAIL mode_hour_blank5: an=%h seg=%h expected an=3f seg=7f", an, seg);
      end
      pulse_scan();
      vectors++;
      if (an !== 6'h3E || seg !== 7'h02) begin
         miscompares++;
         $display("FAIL mode_sec_vis_before: an=%h seg=%h expected an=3e seg=02", an, seg);
      end
      select_mode = 2'd3;
      pulse_5hz();
      vectors++;
      if (an !== 6'h3E || seg !== 7'h02) begin
         miscompares++;
         $display("FAIL mode_change_sec: an=%h seg=%h expected an=3e seg=02", an, seg);
      end
      tick();
      vectors++;
      if (an !== 6'h3E || seg !== 7'h02) begin
         miscompares++;
         $display("FAIL mode_change_hold: an=%h seg=%h expected an=3e seg=02", an, seg);
      end
      pulse_scan(); pulse_scan(); pulse_scan(); pulse_scan();
      vectors++;
      if (an !== 6'h2F || seg !== 7'h24) begin
         miscompares++;
         $display("FAIL mode_change_hour_vis: an=%h seg=%h expected an=2f seg=24", an, seg);
      end
      // blink_off=0 here: a toggle would blank the new hour field
      select_mode = 2'd1;
      pulse_5hz();
      vectors++;
      if (an !== 6'h2F || seg !== 7'h24) begin
         miscompares++;
         $display("FAIL mode_change_priority: an=%h seg=%h expected an=2f seg=24", an, seg);
      end
   endtask

   task automatic test_dp_flash();
      hour = 6'd12; min = 6'd34; sec = 6'd10; select_mode = 2'd0;
      do_reset();
      tick();
      pulse_scan(); pulse_scan();
      vectors++;
      if (an !== 6'h3B || dp !== 1'b0) begin
         miscompares++;
         $display("FAIL dp_sec10_idx2: an=%h dp=%b expected an=3b dp=0", an, dp);
      end
      pulse_scan();
      vectors++;
      if (dp !== 1'b1) begin
         miscompares++;
         $display("FAIL dp_idx3: dp=%b expected 1", dp);
      end
      pulse_scan();
      vectors++;
      if (an !== 6'h2F || dp !== 1'b0) begin
         miscompares++;
         $display("FAIL dp_sec10_idx4: an=%h dp=%b expected an=2f dp=0", an, dp);
      end
      sec = 6'd11;
      tick();
      vectors++;
      if (an !== 6'h2F || dp !== 1'b1) begin
         miscompares++;
         $display("FAIL dp_sec11_idx4: an=%h dp=%b expected an=2f dp=1", an, dp);
      end
      pulse_scan(); pulse_scan(); pulse_scan(); pulse_scan();
      vectors++;
      if (an !== 6'h3B || dp !== 1'b1) begin
         miscompares++;
         $display("FAIL dp_sec11_idx2: an=%h dp=%b expected an=3b dp=1", an, dp);
      end
      sec = 6'd12;
      tick();
      vectors++;
      if (an !== 6'h3B || dp !== 1'b0) begin
         miscompares++;
         $display("FAIL dp_sec12_idx2: an=%h dp=%b expected an=3b dp=0", an, dp);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_scan();
      test_bcd_edges();
      test_blink();
      test_mode_change();
      test_dp_flash();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Display-side consumer of the clock counter outputs.
- Takes hour/min/sec (binary, 6 bits each) and select_mode, and drives a 6-digit, time-multiplexed, common-anode 7-segment display (HH.MM.SS).
- The field selected for setting blinks, so the user sees which field btn_up/btn_dw will change.
- Sits between the counter block and the board pins; one instance per design.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digits; fixed at 6, any other value is unsupported.
- SEG_ACTIVE_LOW, 1, 1 means seg/dp/an are driven active-low; 0 inverts all three output groups.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous assert, active-low
- ena_scan  input  1  one-cycle scan tick (~1 kHz), advances the digit index
- ena_5hz  input  1  one-cycle 5 Hz tick, toggles the blink phase
- select_mode  input  2  0=run, 1=set hour, 2=set min, 3=set sec
- hour  input  6  0..23 binary
- min  input  6  0..59 binary
- sec  input  6  0..59 binary
- an  output  6  digit enables; bit5=hour tens ... bit0=sec units
- seg  output  7  segments {g,f,e,d,c,b,a}
- dp  output  1  decimal point, used as field separator

Behaviour:
- Reset (async, rst_n=0) forces all outputs inactive and clears state:
  - an=6'h3F, seg=7'h7F, dp=1 (all inactive, with SEG_ACTIVE_LOW=1)
  - scan index=0, blink_off=0, last_mode register=0
- Scan index:
  - 3-bit counter 0..5; increments on ena_scan; wraps 5->0.
  - Values 6/7 are unreachable; if ever present, the next ena_scan loads 0.
- Digit mapping:
  - idx0=sec%10, idx1=sec/10
  - idx2=min%10, idx3=min/10
  - idx4=hour%10, idx5=hour/10
- Binary to BCD:
  - Combinational compare ladder valid for 0..63; tens = 0..6, units = 0..9.
  - Out-of-range inputs (e.g. hour=30, sec=62) are displayed literally, not clamped.
- Output register:
  - an/seg/dp are registered; they reflect index, inputs and blink state one clk after the cycle in which they were sampled.
  - Output latency from an ena_scan pulse: exactly 1 cycle.
  - Between ena_scan pulses, outputs are re-evaluated every cycle, so an input change appears within 1 cycle on the current digit.
- Exactly one an bit is active at a time, except when blanked (all inactive).
- Blink:
  - blink_off toggles on every ena_5hz, giving 2.5 Hz with a 50% duty cycle.
  - When select_mode != 0 and blink_off=1, the active digit belongs to the selected field (1: idx5/4, 2: idx3/2, 3: idx1/0) → an all inactive, seg all off.
  - In run mode (select_mode=0) nothing is blanked.
- Mode change:
  - When select_mode differs from last_mode, blink_off is forced to 0 that cycle, so the newly selected field is visible immediately.
  - last_mode is updated every cycle.
  - Mode change has priority over a simultaneous ena_5hz: blink_off=0, no toggle.
- Simultaneous ena_scan and ena_5hz: both take effect in the same cycle.
- dp:
  - Active on idx4 and idx2 (separators after HH and MM).
  - In run mode it is active only while sec[0]=0 (1 Hz separator flash).
  - In set modes it is steadily active.
  - dp is never blanked by blink.
- Segment encoding: standard a..g; digits 0..9 only. BCD values above 9 cannot occur.

Decomposition:
- Package display_pkg holds:
  - mode constants MODE_RUN=0, MODE_HOUR=1, MODE_MIN=2, MODE_SEC=3 (shared with the counter block)
  - SEG_DIGIT[0:9] 7-bit patterns (active-high form; polarity applied at output)
  - digit index constants
- One natural sub-module: bin2bcd_6b, combinational, 6-bit in → 4-bit tens, 4-bit units. Instantiated 3 times, or once muxed by index; either is acceptable.
- Segment lookup stays inline.

Test Plan:
- Reset: rst_n low mid-scan at idx3 → outputs go to an=3F, seg=7F, dp=1 without waiting for clk; after release, the first ena_scan gives idx1 active one cycle later.
- Scan: hour=12, min=34, sec=56, mode 0, 6 ena_scan pulses → an cycles 3E,3D,3B,37,2F,1F with seg patterns for 6,5,4,3,2,1; wraps back to 3E on pulse 7.
- BCD edges: sec=0, 9, 10, 59, and 63 → idx1/idx0 show 0/0, 0/9, 1/0, 5/9, 6/3.
- Blink: mode=2 with ena_5hz every 8 cycles → idx3/idx2 alternate visible/blank each ena_5hz; hour and sec digits are never blanked; dp on idx2 stays active.
- Mode change: blink_off=1 and mode changes 1→3 together with an ena_5hz → blink_off=0 the next cycle; seconds digits are visible; hour digits are visible.
- dp flash: mode 0, sec stepping 10→11→12 → dp on idx4/idx2 is active, inactive, active respectively.
